// File: rtl/multi_sync_edge_detect.sv
// Multi-channel synchronizer, optional debounce filter and edge detector.
// Each async_sig bit passes through a SYNC_STAGES-deep flop chain into the
// outclk domain. It can then be debounced for FILTER_CYCLES cycles. From the
// resulting level the block produces registered edge pulses, sticky edge
// flags and saturating per-channel event counters.
//
// Ports
//   outclk      : sole clock, rising edge
//   reset       : asynchronous, active-high clear of all state
//   async_sig   : CHANNELS asynchronous inputs
//   edge_mode   : 00 rising, 01 falling, 10 both, 11 disabled (shared)
//   clr         : per-channel synchronous clear of edge_flag / edge_count
//   sync_sig    : synchronized (and filtered) level per channel
//   edge_pulse  : one-cycle pulse per qualifying edge
//   edge_flag   : sticky "edge seen" per channel
//   edge_count  : packed counters, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   any_edge    : combinational OR of edge_pulse
module multi_sync_edge_detect #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 0,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                          outclk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           async_sig,
  input  logic [1:0]                    edge_mode,
  input  logic [CHANNELS-1:0]           clr,
  output logic [CHANNELS-1:0]           sync_sig,
  output logic [CHANNELS-1:0]           edge_pulse,
  output logic [CHANNELS-1:0]           edge_flag,
  output logic [CHANNELS*CNT_WIDTH-1:0] edge_count,
  output logic                          any_edge
);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Parameter range guards, evaluated at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("multi_sync_edge_detect: SYNC_STAGES must be 2..4");
  end
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("multi_sync_edge_detect: CHANNELS must be 1..32");
  end
  if (FILTER_CYCLES > 255) begin : g_bad_filter
    $error("multi_sync_edge_detect: FILTER_CYCLES must be 0..255");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 16) begin : g_bad_cnt_width
    $error("multi_sync_edge_detect: CNT_WIDTH must be 1..16");
  end

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] filt;
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] flag_q, flag_d;
  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];

  // Synchronizer chain; only sync_q[0] may go metastable.
  always_ff @(posedge outclk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= async_sig;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_no_filter
    assign filt = raw;
  end else begin : g_filter
    localparam int unsigned FCW = 8;
    localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_CYCLES - 1);

    logic [FCW-1:0]      fcnt_q [CHANNELS];
    logic [FCW-1:0]      fcnt_d [CHANNELS];
    logic [CHANNELS-1:0] filt_q, filt_d;

    // Level follows raw only after raw has differed for FILTER_CYCLES
    // consecutive cycles; any agreement restarts the count.
    always_comb begin
      filt_d = filt_q;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        fcnt_d[c] = '0;
        if (raw[c] != filt_q[c]) begin
          if (fcnt_q[c] == F_LAST) begin
            filt_d[c] = raw[c];
          end else begin
            fcnt_d[c] = fcnt_q[c] + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge outclk or posedge reset) begin
      if (reset) begin
        filt_q <= '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
          fcnt_q[c] <= '0;
        end
      end else begin
        filt_q <= filt_d;
        for (int c = 0; c < int'(CHANNELS); c++) begin
          fcnt_q[c] <= fcnt_d[c];
        end
      end
    end

    assign filt = filt_q;
  end

  // Edge qualification against the previous level; mode 11 yields nothing.
  always_comb begin
    pulse_d = '0;
    case (edge_mode)
      MODE_RISE: pulse_d = filt & ~prev_q;
      MODE_FALL: pulse_d = ~filt & prev_q;
      MODE_BOTH: pulse_d = filt ^ prev_q;
      default:   pulse_d = '0;
    endcase
  end

  // Sticky flag and saturating counter; a pulse in the clear cycle survives.
  always_comb begin
    flag_d = (flag_q & ~clr) | pulse_q;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      cnt_d[c] = cnt_q[c];
      if (clr[c]) begin
        cnt_d[c] = pulse_q[c] ? CNT_WIDTH'(1) : '0;
      end else if (pulse_q[c] && (cnt_q[c] != CNT_MAX)) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge outclk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      prev_q  <= filt;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_pack
    assign edge_count[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c];
  end

  assign sync_sig   = filt;
  assign edge_pulse = pulse_q;
  assign edge_flag  = flag_q;
  assign any_edge   = |pulse_q;

endmodule

// File: tb/tb_multi_sync_edge_detect.sv
// Directed bench for multi_sync_edge_detect: a default instance (F=0,
// 8-bit counters) and a filtered instance (F=3, 2-bit counters) share stimulus.
`timescale 1ns/100ps
module tb_multi_sync_edge_detect;

  logic       outclk = 1'b0;
  logic       reset  = 1'b0;
  logic [3:0] async_sig = '0;
  logic [1:0] edge_mode = 2'b00;
  logic [3:0] clr = '0;

  logic [3:0]  s0_sync, s0_pulse, s0_flag;
  logic [31:0] s0_count;
  logic        s0_any;
  logic [3:0]  s1_sync, s1_pulse, s1_flag;
  logic [7:0]  s1_count;
  logic        s1_any;

  int total = 0;
  int bad   = 0;

  logic meta_on   = 1'b0;
  int   sync_chg  = 0;
  int   sync_badt = 0;

  multi_sync_edge_detect #(
    .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .CNT_WIDTH(8)
  ) dut0 (
    .outclk(outclk), .reset(reset), .async_sig(async_sig), .edge_mode(edge_mode),
    .clr(clr), .sync_sig(s0_sync), .edge_pulse(s0_pulse), .edge_flag(s0_flag),
    .edge_count(s0_count), .any_edge(s0_any)
  );

  multi_sync_edge_detect #(
    .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_WIDTH(2)
  ) dut1 (
    .outclk(outclk), .reset(reset), .async_sig(async_sig), .edge_mode(edge_mode),
    .clr(clr), .sync_sig(s1_sync), .edge_pulse(s1_pulse), .edge_flag(s1_flag),
    .edge_count(s1_count), .any_edge(s1_any)
  );

  always #7 outclk = ~outclk;

  // sync_sig may only move on a rising outclk edge (7 ns mod 14 ns).
  always @(s0_sync) begin
    if (meta_on) begin
      sync_chg++;
      if (($time % 14) != 7) sync_badt++;
    end
  end

  function automatic logic [7:0] cnt0(input int c);
    return s0_count[c*8 +: 8];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge outclk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    total++; if (s0_sync !== 4'h0) begin bad++; $display("FAIL rst_sync0: got %0h want 0", s0_sync); end
    total++; if (s0_pulse !== 4'h0) begin bad++; $display("FAIL rst_pulse0: got %0h want 0", s0_pulse); end
    total++; if (s0_flag !== 4'h0) begin bad++; $display("FAIL rst_flag0: got %0h want 0", s0_flag); end
    total++; if (s0_count !== 32'h0) begin bad++; $display("FAIL rst_count0: got %0h want 0", s0_count); end
    total++; if (s0_any !== 1'b0) begin bad++; $display("FAIL rst_any0: got %0b want 0", s0_any); end
    total++; if (s1_count !== 8'h0) begin bad++; $display("FAIL rst_count1: got %0h want 0", s1_count); end
    @(posedge outclk);
    @(posedge outclk);
    #1 reset = 1'b0;
    cyc(3);
    total++; if (s0_sync !== 4'h0) begin bad++; $display("FAIL idle_sync0: got %0h want 0", s0_sync); end
  endtask

  task automatic test_rising;
    int n;
    edge_mode = 2'b00;
    async_sig[0] = 1'b1;
    cyc(1);
    total++; if (s0_sync[0] !== 1'b0) begin bad++; $display("FAIL rise_sync_early: got %0b want 0", s0_sync[0]); end
    cyc(1);
    total++; if (s0_sync[0] !== 1'b1) begin bad++; $display("FAIL rise_sync: got %0b want 1", s0_sync[0]); end
    total++; if (s0_pulse[0] !== 1'b0) begin bad++; $display("FAIL rise_pulse_early: got %0b want 0", s0_pulse[0]); end
    cyc(1);
    total++; if (s0_pulse !== 4'b0001) begin bad++; $display("FAIL rise_pulse: got %0h want 1", s0_pulse); end
    total++; if (s0_any !== 1'b1) begin bad++; $display("FAIL rise_any: got %0b want 1", s0_any); end
    cyc(1);
    total++; if (s0_pulse[0] !== 1'b0) begin bad++; $display("FAIL rise_pulse_width: got %0b want 0", s0_pulse[0]); end
    total++; if (cnt0(0) !== 8'd1) begin bad++; $display("FAIL rise_count: got %0d want 1", cnt0(0)); end
    total++; if (s0_flag[0] !== 1'b1) begin bad++; $display("FAIL rise_flag: got %0b want 1", s0_flag[0]); end
    total++; if (s1_sync[0] !== 1'b0) begin bad++; $display("FAIL filt_sync_early: got %0b want 0", s1_sync[0]); end
    cyc(1);
    total++; if (s1_sync[0] !== 1'b1) begin bad++; $display("FAIL filt_sync_late: got %0b want 1", s1_sync[0]); end
    async_sig[0] = 1'b0;
    n = 0;
    repeat (8) begin
      cyc(1);
      if (s0_pulse[0]) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL fall_in_rise_mode: got %0d pulses want 0", n); end
    total++; if (cnt0(0) !== 8'd1) begin bad++; $display("FAIL fall_count: got %0d want 1", cnt0(0)); end
  endtask

  task automatic test_both_and_off;
    int n;
    int want_n;
    clr = 4'hF; cyc(1); clr = 4'h0;
    for (int m = 0; m < 2; m++) begin
      edge_mode = (m == 0) ? 2'b10 : 2'b11;
      want_n = (m == 0) ? 10 : 0;
      n = 0;
      for (int p = 0; p < 5; p++) begin
        async_sig[1] = 1'b1;
        repeat (4) begin cyc(1); if (s0_pulse[1]) n++; end
        async_sig[1] = 1'b0;
        repeat (4) begin cyc(1); if (s0_pulse[1]) n++; end
      end
      repeat (8) begin cyc(1); if (s0_pulse[1]) n++; end
      total++; if (n !== want_n) begin bad++; $display("FAIL mode%0d_pulses: got %0d want %0d", m, n, want_n); end
      total++; if (cnt0(1) !== 8'd10) begin bad++; $display("FAIL mode%0d_count: got %0d want 10", m, cnt0(1)); end
    end
    total++; if (s1_count[3:2] !== 2'd3) begin bad++; $display("FAIL both_sat_count1: got %0d want 3", s1_count[3:2]); end
    edge_mode = 2'b00;
  endtask

  task automatic test_filter;
    int n0, n1, hi;
    clr = 4'hF; cyc(1); clr = 4'h0;
    async_sig[2] = 1'b1;
    cyc(2);
    async_sig[2] = 1'b0;
    n0 = 0; n1 = 0; hi = 0;
    repeat (12) begin
      cyc(1);
      if (s1_sync[2]) hi++;
      if (s1_pulse[2]) n1++;
      if (s0_pulse[2]) n0++;
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL glitch_sync: got %0d high cycles want 0", hi); end
    total++; if (n1 !== 0) begin bad++; $display("FAIL glitch_pulse: got %0d want 0", n1); end
    total++; if (n0 !== 1) begin bad++; $display("FAIL glitch_unfiltered: got %0d want 1", n0); end
    async_sig[2] = 1'b1;
    n1 = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (i == 1) begin
        total++; if (s0_sync[2] !== 1'b1) begin bad++; $display("FAIL long_sync0: got %0b want 1", s0_sync[2]); end
      end
      if (i == 3) begin
        total++; if (s1_sync[2] !== 1'b0) begin bad++; $display("FAIL long_sync1_early: got %0b want 0", s1_sync[2]); end
      end
      if (i == 4) begin
        total++; if (s1_sync[2] !== 1'b1) begin bad++; $display("FAIL long_sync1: got %0b want 1", s1_sync[2]); end
        async_sig[2] = 1'b0;
      end
      if (s1_pulse[2]) n1++;
    end
    total++; if (n1 !== 1) begin bad++; $display("FAIL long_pulse: got %0d want 1", n1); end
    total++; if (s1_count[5:4] !== 2'd1) begin bad++; $display("FAIL long_count: got %0d want 1", s1_count[5:4]); end
    total++; if (s1_sync[2] !== 1'b0) begin bad++; $display("FAIL long_sync1_fall: got %0b want 0", s1_sync[2]); end
  endtask

  task automatic test_saturate;
    logic [1:0] want;
    bit got;
    edge_mode = 2'b00;
    clr = 4'hF; cyc(1); clr = 4'h0;
    for (int e = 1; e <= 5; e++) begin
      async_sig[3] = 1'b1;
      cyc(6);
      async_sig[3] = 1'b0;
      cyc(6);
      want = (e > 3) ? 2'd3 : 2'(e);
      total++; if (s1_count[7:6] !== want) begin bad++; $display("FAIL sat_edge%0d: got %0d want %0d", e, s1_count[7:6], want); end
    end
    async_sig[3] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc(1);
      if (s1_pulse[3]) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL sat_pulse6_timeout: got 0 want 1"); end
    clr = 4'b1000;
    cyc(1);
    clr = 4'h0;
    total++; if (s1_count[7:6] !== 2'd1) begin bad++; $display("FAIL clr_with_pulse_count: got %0d want 1", s1_count[7:6]); end
    total++; if (s1_flag[3] !== 1'b1) begin bad++; $display("FAIL clr_with_pulse_flag: got %0b want 1", s1_flag[3]); end
    async_sig[3] = 1'b0;
    cyc(10);
  endtask

  task automatic test_reset_mid;
    int n, idx;
    edge_mode = 2'b00;
    async_sig[1] = 1'b1;
    cyc(1);
    async_sig[0] = 1'b1;
    cyc(3);
    total++; if (s0_pulse[0] !== 1'b1) begin bad++; $display("FAIL pre_rst_pulse: got %0b want 1", s0_pulse[0]); end
    total++; if (cnt0(1) !== 8'd1) begin bad++; $display("FAIL pre_rst_count: got %0d want 1", cnt0(1)); end
    #2 reset = 1'b1;
    #1;
    total++; if (s0_sync !== 4'h0) begin bad++; $display("FAIL mid_rst_sync: got %0h want 0", s0_sync); end
    total++; if (s0_pulse !== 4'h0) begin bad++; $display("FAIL mid_rst_pulse: got %0h want 0", s0_pulse); end
    total++; if (s0_flag !== 4'h0) begin bad++; $display("FAIL mid_rst_flag: got %0h want 0", s0_flag); end
    total++; if (s0_count !== 32'h0) begin bad++; $display("FAIL mid_rst_count: got %0h want 0", s0_count); end
    total++; if (s0_any !== 1'b0) begin bad++; $display("FAIL mid_rst_any: got %0b want 0", s0_any); end
    @(posedge outclk);
    #1 reset = 1'b0;
    n = 0; idx = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (s0_pulse[0]) begin n++; idx = i; end
    end
    total++; if (n !== 1) begin bad++; $display("FAIL post_rst_pulses: got %0d want 1", n); end
    total++; if (idx !== 2) begin bad++; $display("FAIL post_rst_pulse_cycle: got %0d want 2", idx); end
    async_sig = 4'h0;
    cyc(10);
  endtask

  task automatic test_meta;
    int n0, n1, w0, w1;
    bit prev0, prev1;
    edge_mode = 2'b00;
    clr = 4'hF; cyc(1); clr = 4'h0;
    n0 = 0; n1 = 0; w0 = 0; w1 = 0; prev0 = 1'b0; prev1 = 1'b0;
    meta_on = 1'b1;
    fork
      begin
        for (int t = 1; t <= 21000; t++) begin
          #0.1;
          if (t % 5 == 2) async_sig[0] = ~async_sig[0];
          if (t % 6 == 3) async_sig[1] = ~async_sig[1];
        end
        async_sig = 4'h0;
      end
      begin
        repeat (160) begin
          @(posedge outclk);
          #1;
          if (s0_pulse[0]) begin n0++; if (prev0) w0++; end
          if (s0_pulse[1]) begin n1++; if (prev1) w1++; end
          prev0 = s0_pulse[0];
          prev1 = s0_pulse[1];
        end
      end
    join
    meta_on = 1'b0;
    total++; if (w0 !== 0) begin bad++; $display("FAIL meta_width0: got %0d wide pulses want 0", w0); end
    total++; if (w1 !== 0) begin bad++; $display("FAIL meta_width1: got %0d wide pulses want 0", w1); end
    total++; if (cnt0(0) !== 8'(n0)) begin bad++; $display("FAIL meta_count0: got %0d want %0d", cnt0(0), n0); end
    total++; if (cnt0(1) !== 8'(n1)) begin bad++; $display("FAIL meta_count1: got %0d want %0d", cnt0(1), n1); end
    total++; if (sync_badt !== 0) begin bad++; $display("FAIL meta_sync_timing: got %0d off-edge changes want 0", sync_badt); end
    total++; if (sync_chg == 0) begin bad++; $display("FAIL meta_activity: got 0 sync changes want >0"); end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_both_and_off();
    test_filter();
    test_saturate();
    test_reset_mid();
    test_meta();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multi_sync_edge_detect.md
# multi_sync_edge_detect

Parametrised multi-channel synchronizer and edge detector: brings CHANNELS asynchronous inputs into the outclk domain through a SYNC_STAGES-deep flop chain, optionally debounces them, and produces per-channel edge pulses, sticky edge flags and saturating event counters. It replaces the single-bit two-flop synchronizer/edge detector used on switch, key and external-signal inputs throughout the DE1-SoC designs. Downstream FSMs consume edge_pulse directly; software-visible status logic reads edge_flag/edge_count.

## Interface
- CHANNELS, 4: number of independent input channels (1..32)
- SYNC_STAGES, 2: synchronizer flop depth (2..4; values <2 are a synthesis error)
- FILTER_CYCLES, 0: debounce stability requirement in outclk cycles (0 = bypass, max 255)
- CNT_WIDTH, 8: width of each per-channel event counter (1..16)

- outclk  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- async_sig  in  CHANNELS  asynchronous inputs, no timing relation to outclk
- edge_mode  in  2  00 rising, 01 falling, 10 both, 11 detection disabled; quasi-static, shared by all channels
- clr  in  CHANNELS  per-channel synchronous clear of edge_flag and edge_count
- sync_sig  out  CHANNELS  synchronized (and filtered, if enabled) level
- edge_pulse  out  CHANNELS  one-cycle pulse per qualifying edge
- edge_flag  out  CHANNELS  sticky "edge seen" flag
- edge_count  out  CHANNELS*CNT_WIDTH  packed counters, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
- any_edge  out  1  OR of edge_pulse

## Operation
- Per channel: sync chain s[1..SYNC_STAGES], s[1] samples async_sig; raw = s[SYNC_STAGES].
- Filter (FILTER_CYCLES=F>0): per-channel stable counter and filtered level f. If raw == f, counter cleared to 0. If raw != f, counter increments; when counter reaches F-1 and raw still != f, f <= raw and counter clears. So f follows raw after raw differs for F consecutive cycles; any return to f before then restarts the count. F=0: f = raw (no extra register).
- sync_sig = f. Registered previous level p <= f each cycle.
- Edge: rise = f & ~p, fall = ~f & p; qualified per edge_mode; mode 11 gives no pulses. edge_pulse registered: asserted the cycle after the f/p mismatch cycle, for exactly one cycle.
- edge_flag: set by edge_pulse, cleared by clr; same-cycle set and clr -> flag = 1 (set wins).
- edge_count: +1 per edge_pulse, saturates at 2^CNT_WIDTH-1 (never wraps); clr loads 0; same-cycle clr and pulse -> count = 1.
- edge_mode change: affects qualification from the next comparison; never creates a pulse by itself. In mode 10 an edge counts once.
- Channels fully independent; simultaneous edges on all channels all reported same cycle.

## Timing
- Reset (async assert, any time including mid-filter or mid-pulse): all sync flops, f, p, filter counters, edge_pulse, edge_flag, edge_count, any_edge = 0 immediately; sync_sig = 0.
- Reset values are 0: an input held high through reset produces one rising edge after release (documented behaviour, not suppressed).
- Latency, F=0: async_sig stable before outclk edge k -> sync_sig changes after edge k+SYNC_STAGES-1; edge_pulse high between edges k+SYNC_STAGES and k+SYNC_STAGES+1.
- Latency, F>0: add F cycles to both.
- any_edge: combinational OR of registered edge_pulse, same cycle.
- Pulses narrower than one outclk period may be missed (F=0) or are always rejected if shorter than F cycles; never metastable-propagated beyond s[2].

## Test plan
- CHANNELS=4, SYNC_STAGES=2, F=0, mode 00: ch0 0->1 before edge 10 -> sync_sig[0]=1 after edge 11, edge_pulse[0]=1 only in cycle after edge 12, edge_count[0]=1, edge_flag[0]=1; falling edge later gives no pulse.
- Mode 10, ch1 toggled 5 full periods (10 edges, each level held 4 cycles) -> 10 pulses, edge_count[1]=10; mode 11 with same stimulus -> count unchanged.
- F=3: 2-cycle high glitch on ch2 -> no sync_sig change, no pulse; 5-cycle high -> sync_sig[2] rises 3 cycles later than F=0 case, one pulse.
- CNT_WIDTH=2: 5 rising edges on ch3 -> count 1,2,3,3,3 (saturates); clr[3] coincident with 6th edge -> count 1, flag 1.
- Reset asserted asynchronously mid-edge_pulse -> all outputs 0 within same cycle; input held high across release -> exactly one rising pulse after SYNC_STAGES+1 edges.
- 1 ns square wave on async_sig, 14 ns outclk (metastability stress) -> sync_sig only changes on outclk edges, edge_pulse never >1 cycle wide, edge_count equals pulses observed.
